// File: rtl/fifo_wr_ptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_full
//   Write-side pointer and status block of the async PHY TX FIFO (W_CLK domain).
//   Keeps the binary write count, publishes the Gray write pointer towards the
//   read-domain synchroniser, and turns the synchronised Gray read pointer into
//   full / almost-full / fill level. A sticky flag records writes attempted
//   while the FIFO was full.
//
// Ports
//   W_CLK          in   write clock
//   W_rst_n        in   asynchronous active-low reset
//   W_INC          in   write request from the producer
//   W_flush        in   synchronous clear of all write-side state
//   W_ovf_clr      in   synchronous clear of W_ovf
//   Wq2_rptr       in   2-FF synchronised Gray read pointer
//   W_en           out  memory write strobe (combinational)
//   W_addr         out  memory write address (low bits of the binary count)
//   W_ptr          out  registered Gray write pointer
//   W_full         out  FIFO full (registered)
//   W_almost_full  out  fill level >= AF_THRESH (registered)
//   W_level        out  entries written and not yet seen read (0..2**ADDR_FIFO)
//   W_ovf          out  sticky write-while-full flag
// -----------------------------------------------------------------------------
module fifo_wr_ptr_full #(
  parameter int ADDR_FIFO = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                 W_CLK,
  input  logic                 W_rst_n,
  input  logic                 W_INC,
  input  logic                 W_flush,
  input  logic                 W_ovf_clr,
  input  logic [ADDR_FIFO:0]   Wq2_rptr,
  output logic                 W_en,
  output logic [ADDR_FIFO-1:0] W_addr,
  output logic [ADDR_FIFO:0]   W_ptr,
  output logic                 W_full,
  output logic                 W_almost_full,
  output logic [ADDR_FIFO:0]   W_level,
  output logic                 W_ovf
);

  localparam int PW = ADDR_FIFO + 1;
  localparam logic [ADDR_FIFO:0] AF_LVL = PW'(AF_THRESH);

  logic [ADDR_FIFO:0] wbin_q,  wbin_d;
  logic [ADDR_FIFO:0] wgray_q, wgray_d;
  logic [ADDR_FIFO:0] level_q, level_d;
  logic               full_q,  full_d;
  logic               af_q,    af_d;
  logic               ovf_q,   ovf_d;

  logic [ADDR_FIFO:0] rbin;
  logic [ADDR_FIFO:0] wbin_inc;
  logic [ADDR_FIFO:0] wgray_inc;
  logic [ADDR_FIFO:0] level_inc;
  logic [ADDR_FIFO:0] rptr_full_pat;

  // Qualified by W_rst_n so the strobe drops the moment reset is applied,
  // without waiting for the registered full flag to settle.
  assign W_en = W_INC & ~full_q & ~W_flush & W_rst_n;

  // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin            = '0;
    rbin[ADDR_FIFO] = Wq2_rptr[ADDR_FIFO];
    for (int i = ADDR_FIFO - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ Wq2_rptr[i];
    end
  end

  assign wbin_inc  = wbin_q + PW'(W_en);
  assign wgray_inc = (wbin_inc >> 1) ^ wbin_inc;
  assign level_inc = wbin_inc - rbin;

  // Full when the write pointer is exactly one lap ahead of the read pointer;
  // in Gray code that is the read pointer with its top two bits inverted.
  assign rptr_full_pat = {~Wq2_rptr[ADDR_FIFO:ADDR_FIFO-1], Wq2_rptr[ADDR_FIFO-2:0]};

  always_comb begin
    wbin_d  = wbin_inc;
    wgray_d = wgray_inc;
    level_d = level_inc;
    full_d  = (wgray_inc == rptr_full_pat);
    af_d    = (level_inc >= AF_LVL);
    ovf_d   = ovf_q;

    // Setting the overflow flag wins over a simultaneous clear request.
    if (W_INC && full_q) begin
      ovf_d = 1'b1;
    end else if (W_ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (W_flush) begin
      wbin_d  = '0;
      wgray_d = '0;
      level_d = '0;
      full_d  = 1'b0;
      af_d    = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge W_CLK or negedge W_rst_n) begin
    if (!W_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_addr        = wbin_q[ADDR_FIFO-1:0];
  assign W_ptr         = wgray_q;
  assign W_full        = full_q;
  assign W_almost_full = af_q;
  assign W_level       = level_q;
  assign W_ovf         = ovf_q;

endmodule
